// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station: resolves operands at dispatch, wakes entries from CDB lanes
// and issues ready entries in rank order. RS_AGE_ORDER_EN selects oldest-first, else lowest index.
module rs_multi_issue #(
  parameter int DEPTH   = 16,
  parameter int WAYS    = 3,
  parameter int ISSUE_W = 3,
  parameter int CDB_W   = 3,
  parameter int TAG_W   = 5,
  parameter int XLEN    = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [WAYS-1:0]                   dispatch_valid,
  output logic                              dispatch_ready,
  input  logic [WAYS-1:0][6:0]              dispatch_opcode,
  input  logic [WAYS-1:0][TAG_W-1:0]        dispatch_tag,
  input  logic [WAYS-1:0]                   map_hit1,
  input  logic [WAYS-1:0]                   map_hit2,
  input  logic [WAYS-1:0]                   map_ready1,
  input  logic [WAYS-1:0]                   map_ready2,
  input  logic [WAYS-1:0][TAG_W-1:0]        map_tag1,
  input  logic [WAYS-1:0][TAG_W-1:0]        map_tag2,
  input  logic [WAYS-1:0][XLEN-1:0]         opa,
  input  logic [WAYS-1:0][XLEN-1:0]         opb,
  input  logic [WAYS-1:0][XLEN-1:0]         rob_v1,
  input  logic [WAYS-1:0][XLEN-1:0]         rob_v2,
  input  logic [CDB_W-1:0]                  cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag,
  input  logic [CDB_W-1:0][XLEN-1:0]        cdb_value,
  output logic [ISSUE_W-1:0]                issue_valid,
  input  logic [ISSUE_W-1:0]                issue_ready,
  output logic [ISSUE_W-1:0][6:0]           issue_opcode,
  output logic [ISSUE_W-1:0][TAG_W-1:0]     issue_tag,
  output logic [ISSUE_W-1:0][XLEN-1:0]      issue_v1,
  output logic [ISSUE_W-1:0][XLEN-1:0]      issue_v2,
  output logic [$clog2(DEPTH+1)-1:0]        free_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Handshakes: issue port k transfers at a rising edge with issue_valid[k] & issue_ready[k];
  // issue_valid never looks at issue_ready. A dispatch group transfers on |dispatch_valid & dispatch_ready.

  typedef struct packed {
    logic             r;
    logic [TAG_W-1:0] t;
    logic [XLEN-1:0]  v;
  } opnd_t;

  logic [DEPTH-1:0] r_busy, r_r1, r_r2;
  logic [6:0]       r_opcode [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [TAG_W-1:0] r_t1     [DEPTH];
  logic [TAG_W-1:0] r_t2     [DEPTH];
  logic [XLEN-1:0]  r_v1     [DEPTH];
  logic [XLEN-1:0]  r_v2     [DEPTH];

  logic [CW-1:0]    w_free;
  logic             w_accept;
  logic             w_found;
  logic [DEPTH-1:0] w_alloc;
  logic [LW-1:0]    w_alloc_lane [DEPTH];
  opnd_t            w_op1 [WAYS];
  opnd_t            w_op2 [WAYS];
  logic [DEPTH-1:0] w_wk1, w_wk2;
  logic [XLEN-1:0]  w_wv1 [DEPTH];
  logic [XLEN-1:0]  w_wv2 [DEPTH];
  logic [DEPTH-1:0] w_ready, w_fire;
  logic [DEPTH-1:0] w_before [DEPTH];
  logic [CW-1:0]    w_rank [DEPTH];
  logic [IW-1:0]    w_sel [ISSUE_W];

`ifdef RS_AGE_ORDER_EN
  // r_older[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] r_older [DEPTH];
`endif

  always_comb begin
    w_free = CW'(DEPTH);
    for (int i = 0; i < DEPTH; i++) w_free = w_free - CW'(r_busy[i]);
  end

  assign free_count     = w_free;
  assign dispatch_ready = (w_free >= CW'(WAYS)) && !flush;
  assign w_accept       = (|dispatch_valid) && dispatch_ready;

  function automatic opnd_t resolve(input logic hit, input logic rdy,
                                    input logic [TAG_W-1:0] mtag,
                                    input logic [XLEN-1:0] reg_v, input logic [XLEN-1:0] rob_v,
                                    input logic [CDB_W-1:0] cv,
                                    input logic [CDB_W-1:0][TAG_W-1:0] ct,
                                    input logic [CDB_W-1:0][XLEN-1:0] cval);
    opnd_t res;
    res.r = 1'b1;
    res.t = '0;
    res.v = reg_v;
    if (hit && rdy) begin
      res.v = rob_v;
    end else if (hit) begin
      res.r = 1'b0;
      res.t = mtag;
      res.v = '0;
      // Descending scan so the lowest matching CDB lane is the one that sticks.
      for (int c = CDB_W - 1; c >= 0; c--) begin
        if (cv[c] && ct[c] == mtag) begin
          res.r = 1'b1;
          res.v = cval[c];
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_op1[w] = resolve(map_hit1[w], map_ready1[w], map_tag1[w], opa[w], rob_v1[w],
                         cdb_valid, cdb_tag, cdb_value);
      w_op2[w] = resolve(map_hit2[w], map_ready2[w], map_tag2[w], opb[w], rob_v2[w],
                         cdb_valid, cdb_tag, cdb_value);
    end
  end

  // Valid lanes in lane order claim free entries in ascending index order.
  always_comb begin
    w_alloc = '0;
    w_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_alloc_lane[i] = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_found = 1'b0;
      if (w_accept && dispatch_valid[w]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!w_found && !r_busy[i] && !w_alloc[i]) begin
            w_alloc[i]      = 1'b1;
            w_alloc_lane[i] = LW'(w);
            w_found         = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = 1'b0;
      w_wk2[i] = 1'b0;
      w_wv1[i] = '0;
      w_wv2[i] = '0;
      for (int c = CDB_W - 1; c >= 0; c--) begin
        if (cdb_valid[c] && cdb_tag[c] == r_t1[i]) begin
          w_wk1[i] = r_busy[i] & ~r_r1[i];
          w_wv1[i] = cdb_value[c];
        end
        if (cdb_valid[c] && cdb_tag[c] == r_t2[i]) begin
          w_wk2[i] = r_busy[i] & ~r_r2[i];
          w_wv2[i] = cdb_value[c];
        end
      end
    end
  end

  assign w_ready = r_busy & r_r1 & r_r2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
`ifdef RS_AGE_ORDER_EN
        w_before[i][j] = r_older[i][j];
`else
        w_before[i][j] = (j < i);
`endif
      end
    end
  end

  // Rank = number of ready entries that precede this one; port k takes rank k.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) w_rank[i] = w_rank[i] + CW'(w_ready[j] & w_before[i][j]);
    end
  end

  always_comb begin
    w_fire = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      issue_valid[k] = 1'b0;
      w_sel[k]       = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ready[i] && w_rank[i] == CW'(k)) begin
          issue_valid[k] = 1'b1;
          w_sel[k]       = IW'(i);
        end
      end
      issue_opcode[k] = issue_valid[k] ? r_opcode[w_sel[k]] : '0;
      issue_tag[k]    = issue_valid[k] ? r_tag[w_sel[k]]    : '0;
      issue_v1[k]     = issue_valid[k] ? r_v1[w_sel[k]]     : '0;
      issue_v2[k]     = issue_valid[k] ? r_v2[w_sel[k]]     : '0;
      if (issue_valid[k] && issue_ready[k]) w_fire[w_sel[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_opcode[i] <= '0;
        r_tag[i]    <= '0;
        r_t1[i]     <= '0;
        r_t2[i]     <= '0;
        r_v1[i]     <= '0;
        r_v2[i]     <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_busy[i]   <= 1'b1;
          r_opcode[i] <= dispatch_opcode[w_alloc_lane[i]];
          r_tag[i]    <= dispatch_tag[w_alloc_lane[i]];
          r_r1[i]     <= w_op1[w_alloc_lane[i]].r;
          r_t1[i]     <= w_op1[w_alloc_lane[i]].t;
          r_v1[i]     <= w_op1[w_alloc_lane[i]].v;
          r_r2[i]     <= w_op2[w_alloc_lane[i]].r;
          r_t2[i]     <= w_op2[w_alloc_lane[i]].t;
          r_v2[i]     <= w_op2[w_alloc_lane[i]].v;
        end else begin
          if (w_fire[i]) r_busy[i] <= 1'b0;
          if (w_wk1[i]) begin
            r_r1[i] <= 1'b1;
            r_v1[i] <= w_wv1[i];
          end
          if (w_wk2[i]) begin
            r_r2[i] <= 1'b1;
            r_v2[i] <= w_wv2[i];
          end
        end
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // A new entry is younger than all busy entries and than lower lanes of its own group;
  // its column is cleared in every other row so stale bits from a previous owner vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (w_alloc[i])
            r_older[i][j] <= r_busy[j] | (w_alloc[j] && (w_alloc_lane[j] < w_alloc_lane[i]));
          else if (w_alloc[j])
            r_older[i][j] <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_multi_issue.sv
// Bench for rs_multi_issue: directed scenarios plus randomized traffic against a slot-level
// reference model (ages kept as dispatch sequence numbers, selection by sorting).
module tb_rs_multi_issue;
  localparam int DEPTH = 16, WAYS = 3, ISSUE_W = 3, CDB_W = 3, TAG_W = 5, XLEN = 32;

  logic clk = 1'b0;
  logic reset, flush;
  logic [WAYS-1:0]                dispatch_valid;
  logic                           dispatch_ready;
  logic [WAYS-1:0][6:0]           dispatch_opcode;
  logic [WAYS-1:0][TAG_W-1:0]     dispatch_tag;
  logic [WAYS-1:0]                map_hit1, map_hit2, map_ready1, map_ready2;
  logic [WAYS-1:0][TAG_W-1:0]     map_tag1, map_tag2;
  logic [WAYS-1:0][XLEN-1:0]      opa, opb, rob_v1, rob_v2;
  logic [CDB_W-1:0]               cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0]    cdb_tag;
  logic [CDB_W-1:0][XLEN-1:0]     cdb_value;
  logic [ISSUE_W-1:0]             issue_valid, issue_ready;
  logic [ISSUE_W-1:0][6:0]        issue_opcode;
  logic [ISSUE_W-1:0][TAG_W-1:0]  issue_tag;
  logic [ISSUE_W-1:0][XLEN-1:0]   issue_v1, issue_v2;
  logic [$clog2(DEPTH+1)-1:0]     free_count;

  rs_multi_issue #(.DEPTH(DEPTH), .WAYS(WAYS), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
                   .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_opcode(dispatch_opcode), .dispatch_tag(dispatch_tag),
    .map_hit1(map_hit1), .map_hit2(map_hit2), .map_ready1(map_ready1), .map_ready2(map_ready2),
    .map_tag1(map_tag1), .map_tag2(map_tag2),
    .opa(opa), .opb(opb), .rob_v1(rob_v1), .rob_v2(rob_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_tag(issue_tag),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .free_count(free_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, one record per RS slot
  logic             m_busy [DEPTH];
  logic             m_r1 [DEPTH];
  logic             m_r2 [DEPTH];
  logic [6:0]       m_op [DEPTH];
  logic [TAG_W-1:0] m_tag [DEPTH];
  logic [TAG_W-1:0] m_t1 [DEPTH];
  logic [TAG_W-1:0] m_t2 [DEPTH];
  logic [XLEN-1:0]  m_v1 [DEPTH];
  logic [XLEN-1:0]  m_v2 [DEPTH];
  int               m_seq [DEPTH];
  int               m_next_seq = 0;
  logic             p_vld [ISSUE_W];
  int               p_idx [ISSUE_W];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Ready entries listed by index, then ordered by dispatch sequence when age ordering is on.
  task automatic model_pick();
    int q[$];
    int tmp;
    q = {};
    for (int i = 0; i < DEPTH; i++) if (m_busy[i] && m_r1[i] && m_r2[i]) q.push_back(i);
`ifdef RS_AGE_ORDER_EN
    for (int a = 0; a < q.size(); a++)
      for (int b = 0; b + 1 < q.size() - a; b++)
        if (m_seq[q[b]] > m_seq[q[b+1]]) begin
          tmp = q[b]; q[b] = q[b+1]; q[b+1] = tmp;
        end
`endif
    for (int k = 0; k < ISSUE_W; k++) begin
      p_vld[k] = (k < q.size());
      p_idx[k] = p_vld[k] ? q[k] : 0;
    end
  endtask

  task automatic m_resolve(input logic hit, input logic rdy, input logic [TAG_W-1:0] mt,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] rv,
                           output logic r, output logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
    r = 1'b1; t = mt; v = a;
    if (hit && rdy) v = rv;
    else if (hit) begin
      r = 1'b0; v = '0;
      for (int c = 0; c < CDB_W; c++)
        if (cdb_valid[c] && cdb_tag[c] == mt) begin r = 1'b1; v = cdb_value[c]; break; end
    end
  endtask

  task automatic model_step();
    logic pre [DEPTH];
    logic taken [DEPTH];
    int free;
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      return;
    end
    model_pick();
    free = 0;
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = m_busy[i]; taken[i] = 1'b0;
      if (!pre[i]) free++;
    end
    for (int k = 0; k < ISSUE_W; k++) if (p_vld[k] && issue_ready[k]) m_busy[p_idx[k]] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pre[i] && !m_r1[i])
        for (int c = 0; c < CDB_W; c++)
          if (cdb_valid[c] && cdb_tag[c] == m_t1[i]) begin m_r1[i] = 1'b1; m_v1[i] = cdb_value[c]; break; end
      if (pre[i] && !m_r2[i])
        for (int c = 0; c < CDB_W; c++)
          if (cdb_valid[c] && cdb_tag[c] == m_t2[i]) begin m_r2[i] = 1'b1; m_v2[i] = cdb_value[c]; break; end
    end
    if (dispatch_valid != '0 && free >= WAYS) begin
      for (int w = 0; w < WAYS; w++) begin
        if (!dispatch_valid[w]) continue;
        for (int i = 0; i < DEPTH; i++) begin
          if (!pre[i] && !taken[i]) begin
            taken[i] = 1'b1; m_busy[i] = 1'b1;
            m_op[i] = dispatch_opcode[w]; m_tag[i] = dispatch_tag[w];
            m_resolve(map_hit1[w], map_ready1[w], map_tag1[w], opa[w], rob_v1[w], m_r1[i], m_t1[i], m_v1[i]);
            m_resolve(map_hit2[w], map_ready2[w], map_tag2[w], opb[w], rob_v2[w], m_r2[i], m_t2[i], m_v2[i]);
            m_seq[i] = m_next_seq++;
            break;
          end
        end
      end
    end
  endtask

  // Scoreboard: per-cycle comparison of every output against the model
  task automatic check_outputs();
    int free;
    model_pick();
    free = 0;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) free++;
    check("free_count", 64'(free_count), 64'(free));
    check("dispatch_ready", 64'(dispatch_ready), 64'((free >= WAYS) && !flush));
    for (int k = 0; k < ISSUE_W; k++) begin
      check($sformatf("issue_valid[%0d]", k), 64'(issue_valid[k]), 64'(p_vld[k]));
      check($sformatf("issue_opcode[%0d]", k), 64'(issue_opcode[k]), p_vld[k] ? 64'(m_op[p_idx[k]]) : 64'd0);
      check($sformatf("issue_tag[%0d]", k), 64'(issue_tag[k]), p_vld[k] ? 64'(m_tag[p_idx[k]]) : 64'd0);
      check($sformatf("issue_v1[%0d]", k), 64'(issue_v1[k]), p_vld[k] ? 64'(m_v1[p_idx[k]]) : 64'd0);
      check($sformatf("issue_v2[%0d]", k), 64'(issue_v2[k]), p_vld[k] ? 64'(m_v2[p_idx[k]]) : 64'd0);
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  // Driver tasks
  task automatic clear_inputs();
    flush = 1'b0; dispatch_valid = '0; dispatch_opcode = '0; dispatch_tag = '0;
    map_hit1 = '0; map_hit2 = '0; map_ready1 = '0; map_ready2 = '0;
    map_tag1 = '0; map_tag2 = '0; opa = '0; opb = '0; rob_v1 = '0; rob_v2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; issue_ready = '0;
  endtask

  task automatic set_lane(input int w, input logic [6:0] op, input logic [TAG_W-1:0] t,
                          input logic h1, input logic rd1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] a,
                          input logic h2, input logic rd2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] b);
    dispatch_valid[w] = 1'b1; dispatch_opcode[w] = op; dispatch_tag[w] = t;
    map_hit1[w] = h1; map_ready1[w] = rd1; map_tag1[w] = t1; opa[w] = a; rob_v1[w] = a + 32'd1000;
    map_hit2[w] = h2; map_ready2[w] = rd2; map_tag2[w] = t2; opb[w] = b; rob_v2[w] = b + 32'd1000;
  endtask

  task automatic set_cdb(input int c, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    cdb_valid[c] = 1'b1; cdb_tag[c] = t; cdb_value[c] = v;
  endtask

  task automatic grp_basic();
    clear_inputs();
    set_lane(0, 7'b0000011, 5'd4, 1'b0, 1'b0, 5'd0, 32'd11, 1'b0, 1'b0, 5'd0, 32'd14);
    set_lane(1, 7'b0100011, 5'd5, 1'b0, 1'b0, 5'd0, 32'd12, 1'b0, 1'b0, 5'd0, 32'd15);
    set_lane(2, 7'b0010011, 5'd6, 1'b0, 1'b0, 5'd0, 32'd13, 1'b0, 1'b0, 5'd0, 32'd16);
  endtask

  task automatic flush_with_dispatch();
    grp_basic();
    flush = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("flush_free", 64'(free_count), 64'd16);
    check("flush_valid", 64'(issue_valid), 64'd0);
    tick();
  endtask

  task automatic random_inputs();
    clear_inputs();
    reset = ($urandom_range(0, 199) == 0);
    flush = ($urandom_range(0, 39) == 0);
    if ($urandom_range(0, 2) != 0) dispatch_valid = 3'($urandom_range(1, 7));
    for (int w = 0; w < WAYS; w++) begin
      dispatch_opcode[w] = 7'($urandom_range(0, 127));
      dispatch_tag[w] = 5'($urandom_range(0, 31));
      map_hit1[w] = 1'($urandom_range(0, 1)); map_ready1[w] = 1'($urandom_range(0, 1));
      map_hit2[w] = 1'($urandom_range(0, 1)); map_ready2[w] = 1'($urandom_range(0, 1));
      map_tag1[w] = 5'($urandom_range(0, 7)); map_tag2[w] = 5'($urandom_range(0, 7));
      opa[w] = $urandom; opb[w] = $urandom; rob_v1[w] = $urandom; rob_v2[w] = $urandom;
    end
    cdb_valid = 3'($urandom_range(0, 7));
    for (int c = 0; c < CDB_W; c++) begin
      cdb_tag[c] = 5'($urandom_range(0, 7));
      cdb_value[c] = $urandom;
    end
    issue_ready = 3'($urandom_range(0, 7));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0; m_seq[i] = 0;
      m_op[i] = '0; m_tag[i] = '0; m_t1[i] = '0; m_t2[i] = '0; m_v1[i] = '0; m_v2[i] = '0;
    end
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_free", 64'(free_count), 64'd16);
    check("rst_dready", 64'(dispatch_ready), 64'd1);
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_tag0", 64'(issue_tag[0]), 64'd0);
    tick();

    // Basic group: operands straight from opa/opb, issue next cycle
    grp_basic();
    tick();
    clear_inputs();
    #1;
    check("basic_valid", 64'(issue_valid), 64'b111);
    check("basic_tag0", 64'(issue_tag[0]), 64'd4);
    check("basic_tag1", 64'(issue_tag[1]), 64'd5);
    check("basic_tag2", 64'(issue_tag[2]), 64'd6);
    check("basic_v1_0", 64'(issue_v1[0]), 64'd11);
    check("basic_v2_2", 64'(issue_v2[2]), 64'd16);
    check("basic_free", 64'(free_count), 64'd13);

    // Fill until fewer than WAYS entries remain; a further group is refused
    for (int g = 0; g < 4; g++) begin
      grp_basic();
      tick();
    end
    clear_inputs();
    #1;
    check("full_free", 64'(free_count), 64'd1);
    check("full_dready", 64'(dispatch_ready), 64'd0);
    grp_basic();
    tick();
    clear_inputs();
    #1;
    check("sixth_free", 64'(free_count), 64'd1);
    for (int r = 0; r < 3; r++) begin
      #1;
      check("stall_valid", 64'(issue_valid), 64'b111);
      check("stall_tag0", 64'(issue_tag[0]), 64'd4);
      tick();
    end
    flush_with_dispatch();

    // Wait on tags 1..6, wake operand 1 then operand 2
    clear_inputs();
    set_lane(0, 7'h33, 5'd8, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd4, 32'd0);
    set_lane(1, 7'h33, 5'd9, 1'b1, 1'b0, 5'd2, 32'd0, 1'b1, 1'b0, 5'd5, 32'd0);
    set_lane(2, 7'h33, 5'd10, 1'b1, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0, 5'd6, 32'd0);
    issue_ready = 3'b111;
    tick();
    clear_inputs();
    issue_ready = 3'b111;
    #1;
    check("wait_valid", 64'(issue_valid), 64'd0);
    set_cdb(0, 5'd1, 32'd31); set_cdb(1, 5'd2, 32'd32); set_cdb(2, 5'd3, 32'd33);
    tick();
    clear_inputs();
    issue_ready = 3'b111;
    #1;
    check("half_valid", 64'(issue_valid), 64'd0);
    set_cdb(0, 5'd4, 32'd41); set_cdb(1, 5'd5, 32'd42); set_cdb(2, 5'd6, 32'd43);
    tick();
    clear_inputs();
    issue_ready = 3'b111;
    #1;
    check("wake_valid", 64'(issue_valid), 64'b111);
    check("wake_v1_0", 64'(issue_v1[0]), 64'd31);
    check("wake_v1_2", 64'(issue_v1[2]), 64'd33);
    check("wake_v2_1", 64'(issue_v2[1]), 64'd42);
    tick();

    // Dispatch-cycle CDB bypass
    clear_inputs();
    set_lane(0, 7'h13, 5'd11, 1'b1, 1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 32'd5);
    set_cdb(0, 5'd7, 32'd99);
    tick();
    clear_inputs();
    issue_ready = 3'b111;
    #1;
    check("byp_valid", 64'(issue_valid), 64'b001);
    check("byp_v1", 64'(issue_v1[0]), 64'd99);
    check("byp_v2", 64'(issue_v2[0]), 64'd5);
    tick();

    // Ordering: A (waiting, entry 1) dispatched before B (ready, entry 0)
    clear_inputs();
    set_lane(0, 7'h13, 5'd12, 1'b0, 1'b0, 5'd0, 32'd1, 1'b0, 1'b0, 5'd0, 32'd2);
    issue_ready = 3'b111;
    tick();
    clear_inputs();
    set_lane(0, 7'h13, 5'd13, 1'b1, 1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 5'd0, 32'd3);
    issue_ready = 3'b111;
    tick();
    clear_inputs();
    set_lane(0, 7'h13, 5'd14, 1'b0, 1'b0, 5'd0, 32'd4, 1'b0, 1'b0, 5'd0, 32'd5);
    tick();
    clear_inputs();
    set_cdb(0, 5'd9, 32'd77);
    tick();
    clear_inputs();
    for (int r = 0; r < 3; r++) begin
      #1;
      check("order_valid", 64'(issue_valid), 64'b011);
`ifdef RS_AGE_ORDER_EN
      check("order_port0", 64'(issue_tag[0]), 64'd13);
      check("order_port1", 64'(issue_tag[1]), 64'd14);
`else
      check("order_port0", 64'(issue_tag[0]), 64'd14);
      check("order_port1", 64'(issue_tag[1]), 64'd13);
`endif
      tick();
    end
    flush_with_dispatch();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      random_inputs();
      tick();
    end
    clear_inputs();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
